// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: drains the pipe, flushes, commits trap CSRs and
// redirects fetch to the mtvec-selected handler.
module interrupt_sequencer #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   irq_valid,
   input  logic [3:0]             irq_code,
   input  logic                   pipe_idle,
   input  logic [XLEN-1:0]        next_pc,
   input  logic [XLEN-1:0]        trap_vector,
   input  logic                   redirect_ready,
   output logic                   hold,
   output logic                   flush,
   output logic                   csr_we,
   output logic [XLEN-1:0]        csr_cause,
   output logic [XLEN-1:0]        csr_epc,
   output logic                   redirect_valid,
   output logic [XLEN-1:0]        redirect_pc,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] irq_count
);

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StFlush,
      StCommit,
      StRedirect
   } state_e;

   state_e                 state_q, state_d;
   logic [3:0]             code_q;
   logic [XLEN-1:0]        epc_q;
   logic [XLEN-1:0]        redirect_pc_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [XLEN-1:0]        base;
   logic [XLEN-1:0]        vec_pc;
   logic                   take;

   // Abort (irq_valid low) wins over entering FLUSH.
   assign take   = (state_q == StDrain) && irq_valid && pipe_idle;
   assign base   = {trap_vector[XLEN-1:2], 2'b00};
   assign vec_pc = base + (XLEN'(code_q) << 2);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (irq_valid) state_d = StDrain;
         StDrain: begin
            if (!irq_valid)     state_d = StIdle;
            else if (pipe_idle) state_d = StFlush;
         end
         StFlush:    state_d = StCommit;
         StCommit:   state_d = StRedirect;
         StRedirect: if (redirect_ready) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= StIdle;
         code_q        <= 4'd0;
         epc_q         <= '0;
         redirect_pc_q <= '0;
         count_q       <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            code_q <= irq_code;
            epc_q  <= next_pc;
         end
         if (state_q == StFlush) begin
            redirect_pc_q <= (trap_vector[1:0] == 2'b01) ? vec_pc : base;
         end
         if ((state_q == StRedirect) && redirect_ready) begin
            count_q <= count_q + COUNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      hold           = (state_q != StIdle);
      busy           = (state_q != StIdle);
      flush          = (state_q == StFlush);
      csr_we         = (state_q == StCommit);
      redirect_valid = (state_q == StRedirect);
   end

   assign csr_cause   = {1'b1, {(XLEN-5){1'b0}}, code_q};
   assign csr_epc     = epc_q;
   assign redirect_pc = redirect_pc_q;
   assign irq_count   = count_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer.
module tb_interrupt_sequencer;

   localparam int XLEN = 32;
   // Narrow counter keeps the wrap scenario short; wrap logic is width-generic.
   localparam int CW   = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            irq_valid;
   logic [3:0]      irq_code;
   logic            pipe_idle;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] trap_vector;
   logic            redirect_ready;
   logic            hold;
   logic            flush;
   logic            csr_we;
   logic [XLEN-1:0] csr_cause;
   logic [XLEN-1:0] csr_epc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            busy;
   logic [CW-1:0]   irq_count;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   interrupt_sequencer #(.XLEN(XLEN), .COUNT_WIDTH(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .irq_valid      (irq_valid),
      .irq_code       (irq_code),
      .pipe_idle      (pipe_idle),
      .next_pc        (next_pc),
      .trap_vector    (trap_vector),
      .redirect_ready (redirect_ready),
      .hold           (hold),
      .flush          (flush),
      .csr_we         (csr_we),
      .csr_cause      (csr_cause),
      .csr_epc        (csr_epc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .irq_count      (irq_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full trap with ready fetch; returns the handler address seen in REDIRECT.
   task automatic do_trap(input logic [3:0] code, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] tv, output logic [XLEN-1:0] rpc,
                          output logic ok);
      ok             = 1'b0;
      rpc            = '0;
      irq_code       = code;
      next_pc        = pc;
      trap_vector    = tv;
      pipe_idle      = 1'b1;
      redirect_ready = 1'b1;
      irq_valid      = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (csr_we) irq_valid = 1'b0;
         if (redirect_valid) begin
            rpc = redirect_pc;
            ok  = 1'b1;
            break;
         end
      end
      irq_valid = 1'b0;
      tick();
      if (busy) ok = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; irq_valid = 1'b0; irq_code = 4'd0; pipe_idle = 1'b0;
      next_pc = '0; trap_vector = '0; redirect_ready = 1'b0;
      tick(); tick();
      n_total++; if (hold !== 1'b0) $display("FAIL reset_hold got=%0h exp=0", hold); else n_pass++;
      n_total++; if (flush !== 1'b0) $display("FAIL reset_flush got=%0h exp=0", flush); else n_pass++;
      n_total++; if (csr_we !== 1'b0) $display("FAIL reset_csr_we got=%0h exp=0", csr_we); else n_pass++;
      n_total++; if (redirect_valid !== 1'b0) $display("FAIL reset_rv got=%0h exp=0", redirect_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else n_pass++;
      n_total++; if (irq_count !== 8'h00) $display("FAIL reset_count got=%0h exp=0", irq_count); else n_pass++;
      n_total++; if (csr_cause !== 32'h8000_0000) $display("FAIL reset_cause got=%0h exp=80000000", csr_cause); else n_pass++;
      n_total++; if (csr_epc !== 32'h0) $display("FAIL reset_epc got=%0h exp=0", csr_epc); else n_pass++;
      n_total++; if (redirect_pc !== 32'h0) $display("FAIL reset_rpc got=%0h exp=0", redirect_pc); else n_pass++;
      rst = 1'b1;
      tick();
      n_total++; if (busy !== 1'b0) $display("FAIL idle_no_irq_busy got=%0h exp=0", busy); else n_pass++;
   endtask

   task automatic test_fast_path();
      irq_code = 4'd7; next_pc = 32'h8000_0100; trap_vector = 32'h8000_0000;
      pipe_idle = 1'b1; redirect_ready = 1'b1; irq_valid = 1'b1;
      tick(); // cycle 1: DRAIN
      n_total++; if (hold !== 1'b1) $display("FAIL fast_hold_c1 got=%0h exp=1", hold); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL fast_busy_c1 got=%0h exp=1", busy); else n_pass++;
      n_total++; if (flush !== 1'b0) $display("FAIL fast_flush_c1 got=%0h exp=0", flush); else n_pass++;
      tick(); // cycle 2: FLUSH
      n_total++; if (flush !== 1'b1) $display("FAIL fast_flush_c2 got=%0h exp=1", flush); else n_pass++;
      n_total++; if (csr_we !== 1'b0) $display("FAIL fast_csr_we_c2 got=%0h exp=0", csr_we); else n_pass++;
      irq_code = 4'd3; next_pc = 32'h1234_5678; // must be ignored after FLUSH
      tick(); // cycle 3: COMMIT
      n_total++; if (csr_we !== 1'b1) $display("FAIL fast_csr_we_c3 got=%0h exp=1", csr_we); else n_pass++;
      n_total++; if (flush !== 1'b0) $display("FAIL fast_flush_c3 got=%0h exp=0", flush); else n_pass++;
      n_total++; if (csr_cause !== 32'h8000_0007) $display("FAIL fast_cause got=%0h exp=80000007", csr_cause); else n_pass++;
      n_total++; if (csr_epc !== 32'h8000_0100) $display("FAIL fast_epc got=%0h exp=80000100", csr_epc); else n_pass++;
      irq_valid = 1'b0;
      tick(); // cycle 4: REDIRECT
      n_total++; if (redirect_valid !== 1'b1) $display("FAIL fast_rv_c4 got=%0h exp=1", redirect_valid); else n_pass++;
      n_total++; if (csr_we !== 1'b0) $display("FAIL fast_csr_we_c4 got=%0h exp=0", csr_we); else n_pass++;
      n_total++; if (redirect_pc !== 32'h8000_0000) $display("FAIL fast_rpc got=%0h exp=80000000", redirect_pc); else n_pass++;
      tick(); // cycle 5: IDLE
      n_total++; if (busy !== 1'b0) $display("FAIL fast_busy_c5 got=%0h exp=0", busy); else n_pass++;
      n_total++; if (hold !== 1'b0) $display("FAIL fast_hold_c5 got=%0h exp=0", hold); else n_pass++;
      n_total++; if (redirect_valid !== 1'b0) $display("FAIL fast_rv_c5 got=%0h exp=0", redirect_valid); else n_pass++;
      n_total++; if (irq_count !== 8'd1) $display("FAIL fast_count got=%0h exp=1", irq_count); else n_pass++;
   endtask

   task automatic test_vector_modes();
      logic [XLEN-1:0] rpc;
      logic            ok;
      do_trap(4'd11, 32'h8000_0200, 32'h8000_0001, rpc, ok);
      n_total++; if (ok !== 1'b1) $display("FAIL vec_timeout got=%0h exp=1", ok); else n_pass++;
      n_total++; if (rpc !== 32'h8000_002C) $display("FAIL vec_rpc got=%0h exp=8000002c", rpc); else n_pass++;
      do_trap(4'd5, 32'h8000_0204, 32'h8000_0002, rpc, ok);
      n_total++; if (rpc !== 32'h8000_0000) $display("FAIL mode10_rpc got=%0h exp=80000000", rpc); else n_pass++;
      do_trap(4'd2, 32'h8000_0208, 32'h8000_0013, rpc, ok);
      n_total++; if (rpc !== 32'h8000_0010) $display("FAIL mode11_rpc got=%0h exp=80000010", rpc); else n_pass++;
      do_trap(4'd3, 32'h8000_020C, 32'hFFFF_FFFD, rpc, ok);
      n_total++; if (rpc !== 32'h0000_0008) $display("FAIL vec_wrap_rpc got=%0h exp=8", rpc); else n_pass++;
      n_total++; if (irq_count !== 8'd5) $display("FAIL modes_count got=%0h exp=5", irq_count); else n_pass++;
   endtask

   task automatic test_abort();
      logic bad = 1'b0;
      irq_valid = 1'b1; pipe_idle = 1'b0; irq_code = 4'd9;
      tick(); // DRAIN
      for (int i = 0; i < 5; i++) begin
         if (flush || csr_we || redirect_valid || !hold) bad = 1'b1;
         tick();
      end
      n_total++; if (busy !== 1'b1) $display("FAIL drain_stall_busy got=%0h exp=1", busy); else n_pass++;
      irq_valid = 1'b0;
      tick();
      n_total++; if (bad !== 1'b0) $display("FAIL drain_outputs got=%0h exp=0", bad); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%0h exp=0", busy); else n_pass++;
      n_total++; if (irq_count !== 8'd5) $display("FAIL abort_count got=%0h exp=5", irq_count); else n_pass++;
      // Abort beats FLUSH when irq_valid drops just as the pipe goes idle.
      irq_valid = 1'b1; pipe_idle = 1'b0;
      tick();
      irq_valid = 1'b0; pipe_idle = 1'b1;
      tick();
      n_total++; if (flush !== 1'b0) $display("FAIL abort_prio_flush got=%0h exp=0", flush); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL abort_prio_busy got=%0h exp=0", busy); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic bad = 1'b0;
      irq_code = 4'd4; next_pc = 32'h8000_0300; trap_vector = 32'h8000_0001;
      pipe_idle = 1'b1; redirect_ready = 1'b0; irq_valid = 1'b1;
      tick(); tick(); tick(); // DRAIN, FLUSH, COMMIT
      irq_valid = 1'b0;
      tick(); // REDIRECT
      trap_vector = 32'h0000_1001; // later mtvec changes must not move the held target
      for (int i = 0; i < 3; i++) begin
         if (!redirect_valid || !hold || redirect_pc !== 32'h8000_0010) bad = 1'b1;
         tick();
      end
      n_total++; if (bad !== 1'b0) $display("FAIL bp_held got=%0h exp=0", bad); else n_pass++;
      n_total++; if (redirect_pc !== 32'h8000_0010) $display("FAIL bp_rpc got=%0h exp=80000010", redirect_pc); else n_pass++;
      n_total++; if (irq_count !== 8'd5) $display("FAIL bp_count_wait got=%0h exp=5", irq_count); else n_pass++;
      redirect_ready = 1'b1;
      tick();
      n_total++; if (busy !== 1'b0) $display("FAIL bp_idle got=%0h exp=0", busy); else n_pass++;
      n_total++; if (irq_count !== 8'd6) $display("FAIL bp_count got=%0h exp=6", irq_count); else n_pass++;
   endtask

   task automatic test_reset_commit();
      irq_code = 4'd6; next_pc = 32'h8000_0400; trap_vector = 32'h8000_0000;
      pipe_idle = 1'b1; redirect_ready = 1'b1; irq_valid = 1'b1;
      tick(); tick(); tick(); // COMMIT
      n_total++; if (csr_we !== 1'b1) $display("FAIL rc_commit got=%0h exp=1", csr_we); else n_pass++;
      rst = 1'b0; irq_valid = 1'b0;
      tick();
      n_total++; if ({hold, flush, csr_we, redirect_valid, busy} !== 5'b0)
         $display("FAIL rc_outputs got=%0b exp=0", {hold, flush, csr_we, redirect_valid, busy});
      else n_pass++;
      n_total++; if (irq_count !== 8'd0) $display("FAIL rc_count got=%0h exp=0", irq_count); else n_pass++;
      n_total++; if (csr_epc !== 32'h0) $display("FAIL rc_epc got=%0h exp=0", csr_epc); else n_pass++;
      rst = 1'b1;
      tick(); tick();
      n_total++; if (busy !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL rc_no_resume got=%0h exp=0", busy); else n_pass++;
      n_total++; if (irq_count !== 8'd0) $display("FAIL rc_count_after got=%0h exp=0", irq_count); else n_pass++;
   endtask

   task automatic test_back_to_back();
      irq_code = 4'd1; pipe_idle = 1'b1; redirect_ready = 1'b1; irq_valid = 1'b1;
      tick(); tick(); tick(); tick(); // irq_valid kept high through the whole trap
      n_total++; if (redirect_valid !== 1'b1) $display("FAIL b2b_rv got=%0h exp=1", redirect_valid); else n_pass++;
      tick(); // IDLE
      n_total++; if (busy !== 1'b0) $display("FAIL b2b_idle got=%0h exp=0", busy); else n_pass++;
      n_total++; if (irq_count !== 8'd1) $display("FAIL b2b_count got=%0h exp=1", irq_count); else n_pass++;
      tick(); // restarts into DRAIN
      n_total++; if (busy !== 1'b1) $display("FAIL b2b_restart got=%0h exp=1", busy); else n_pass++;
      irq_valid = 1'b0;
      tick();
      n_total++; if (busy !== 1'b0) $display("FAIL b2b_abort got=%0h exp=0", busy); else n_pass++;
   endtask

   task automatic test_count_wrap();
      logic [XLEN-1:0] rpc;
      logic            ok;
      logic            all_ok = 1'b1;
      for (int i = 0; i < 254; i++) begin
         do_trap(4'd2, 32'h100, 32'h200, rpc, ok);
         if (!ok) all_ok = 1'b0;
      end
      n_total++; if (all_ok !== 1'b1) $display("FAIL wrap_timeout got=%0h exp=1", all_ok); else n_pass++;
      n_total++; if (irq_count !== 8'hFF) $display("FAIL wrap_max got=%0h exp=ff", irq_count); else n_pass++;
      do_trap(4'd2, 32'h100, 32'h200, rpc, ok);
      n_total++; if (irq_count !== 8'h00) $display("FAIL wrap_zero got=%0h exp=0", irq_count); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fast_path();
      test_vector_modes();
      test_abort();
      test_backpressure();
      test_reset_commit();
      test_back_to_back();
      test_count_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
